bcd_conv_sched: RTL and testbench

Schedules the shared free-running binary-to-BCD converter for the calculator display path. Up to N_REQ requesters (operand A entry, operand B entry, result) post 12-bit values. The block buffers each value per channel and grants the converter round-robin. It drives the converter input and discards the stale in-flight conversion. It then publishes the matching 16-bit BCD word, tagged with its source, to the seven-segment display logic.

---
 rtl/bcd_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/bcd_conv_sched.sv | 132 +++++++++++++
 tb/tb_bcd_conv_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the binary-to-BCD converter scheduler.
package bcd_sched_pkg;

  localparam int DEF_N_REQ   = 3;
  localparam int DEF_W_BIN   = 12;
  localparam int DEF_W_BCD   = 16;
  localparam int DEF_TIMEOUT = 127;
  localparam int CONV_PERIOD = 62;

  localparam logic [3:0] NEG_TAG = 4'hE;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    CONVERT,
    PUBLISH
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first pending channel at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]         pend,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int IDXW = $clog2(N_REQ);

  logic [IDXW:0]   w_sum;
  logic [IDXW-1:0] w_cand;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, rr_ptr} + (IDXW+1)'(k);
      if (w_sum >= (IDXW+1)'(N_REQ)) w_sum = w_sum - (IDXW+1)'(N_REQ);
      w_cand = w_sum[IDXW-1:0];
      if (!any && pend[w_cand]) begin
        any           = 1'b1;
        idx           = w_cand;
        grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Buffers per-channel binary values, grants the shared free-running BCD converter
// round-robin, discards the in-flight stale result and publishes the tagged BCD word.
module bcd_conv_sched
  import bcd_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W_BIN   = DEF_W_BIN,
  parameter int W_BCD   = DEF_W_BCD,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*W_BIN-1:0] req_val,
  output logic [N_REQ-1:0]       ack,
  output logic [W_BIN-1:0]       conv_bin,
  input  logic [W_BCD-1:0]       conv_bcd,
  input  logic                   conv_ready,
  output logic [W_BCD-1:0]       disp_bcd,
  output logic [1:0]             disp_src,
  output logic                   disp_valid,
  output logic                   busy,
  output logic                   err
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int WDW  = $clog2(TIMEOUT);

  state_t           r_state, w_next;
  logic [W_BIN-1:0] r_hold [N_REQ];
  logic [N_REQ-1:0] r_pend, w_pend_nxt, w_grant;
  logic [IDXW-1:0]  r_rr, r_sel, w_idx;
  logic             w_any, w_take, w_timeout, w_wd_done;
  logic [W_BIN-1:0] r_act, r_conv_bin;
  logic [WDW-1:0]   r_wd;
  logic [W_BCD-1:0] r_disp_bcd;
  logic [1:0]       r_disp_src;
  logic             r_err;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .pend   (r_pend),
    .rr_ptr (r_rr),
    .grant  (w_grant),
    .idx    (w_idx),
    .any    (w_any)
  );

  assign w_wd_done = (r_wd == WDW'(TIMEOUT - 1));

  // conv_ready takes priority over a watchdog expiry on the same cycle.
  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    w_timeout  = 1'b0;
    ack        = '0;
    disp_valid = 1'b0;
    case (r_state)
      IDLE:    if (w_any) begin
                 w_take = 1'b1;
                 w_next = LOAD;
               end
      LOAD:    w_next = FLUSH;
      FLUSH,
      CONVERT: if (conv_ready) begin
                 w_next = (r_state == FLUSH) ? CONVERT : PUBLISH;
               end else if (w_wd_done) begin
                 w_timeout = 1'b1;
                 w_next    = IDLE;
               end
      PUBLISH: begin
                 disp_valid = 1'b1;
                 ack[r_sel] = 1'b1;
                 w_next     = IDLE;
               end
      default: w_next = IDLE;
    endcase
  end

  // A request on the grant cycle re-sets the bit the grant just cleared.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_take)    w_pend_nxt = w_pend_nxt & ~w_grant;
    if (w_timeout) w_pend_nxt[r_sel] = 1'b1;
    w_pend_nxt = w_pend_nxt | req;
  end

  // NOTE: hold registers are qualified by pend, which is reset, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) r_hold[i] <= req_val[i*W_BIN +: W_BIN];
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_rr       <= '0;
      r_sel      <= '0;
      r_act      <= '0;
      r_wd       <= '0;
      r_conv_bin <= '0;
      r_disp_bcd <= '0;
      r_disp_src <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend_nxt;
      if (w_next != r_state)                        r_wd <= '0;
      else if (r_state == FLUSH || r_state == CONVERT) r_wd <= r_wd + 1'b1;
      if (w_take) begin
        r_act <= r_hold[w_idx];
        r_sel <= w_idx;
        r_rr  <= (w_idx == IDXW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      if (r_state == LOAD) r_conv_bin <= r_act;
      if (r_state == CONVERT && conv_ready) begin
        r_disp_bcd <= conv_bcd;
        r_disp_src <= 2'(r_sel);
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign conv_bin = r_conv_bin;
  assign disp_bcd = r_disp_bcd;
  assign disp_src = r_disp_src;
  assign err      = r_err;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched with a behavioural free-running 62-cycle converter.
module tb_bcd_conv_sched;
  import bcd_sched_pkg::*;

  localparam int N_REQ   = 3;
  localparam int W_BIN   = 12;
  localparam int W_BCD   = 16;
  localparam int TIMEOUT = 127;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*W_BIN-1:0] req_val;
  logic [N_REQ-1:0]       ack;
  logic [W_BIN-1:0]       conv_bin;
  logic [W_BCD-1:0]       conv_bcd;
  logic                   conv_ready;
  logic [W_BCD-1:0]       disp_bcd;
  logic [1:0]             disp_src;
  logic                   disp_valid;
  logic                   busy;
  logic                   err;

  logic                   stall;
  int                     conv_cnt = 17;
  logic [W_BIN-1:0]       conv_in  = '0;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int ack_cnt [N_REQ] = '{0, 0, 0};

  typedef struct {
    int               ch;
    logic [W_BIN-1:0] val;
    logic [W_BCD-1:0] exp_bcd;
  } vec_t;

  vec_t vecs [5];

  bcd_conv_sched #(
    .N_REQ(N_REQ), .W_BIN(W_BIN), .W_BCD(W_BCD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_val    (req_val),
    .ack        (ack),
    .conv_bin   (conv_bin),
    .conv_bcd   (conv_bcd),
    .conv_ready (conv_ready),
    .disp_bcd   (disp_bcd),
    .disp_src   (disp_src),
    .disp_valid (disp_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Converter model: result of the value captured at the previous ready cycle;
  // bin_in is captured at the end of each ready cycle. No reset.
  function automatic logic [W_BCD-1:0] to_bcd(input logic [W_BIN-1:0] b);
    int v;
    logic [W_BCD-1:0] r;
    if (b[11:8] == NEG_TAG) begin
      v = int'(b[7:0]);
      r = {NEG_TAG, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    end else begin
      v = int'(b);
      r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    end
    return r;
  endfunction

  assign conv_ready = (conv_cnt == CONV_PERIOD - 1) && !stall;
  assign conv_bcd   = to_bcd(conv_in);

  always @(posedge clk) begin
    if (conv_cnt == CONV_PERIOD - 1) begin
      conv_cnt <= 0;
      conv_in  <= conv_bin;
    end else begin
      conv_cnt <= conv_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (disp_valid) valid_cnt <= valid_cnt + 1;
    for (int i = 0; i < N_REQ; i++) begin
      if (ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Request strobe on the next edge; returns #1 after that edge.
  task automatic post(input int ch, input logic [W_BIN-1:0] v);
    req[ch]                    = 1'b1;
    req_val[ch*W_BIN +: W_BIN] = v;
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(posedge clk); #1;
      n++;
      if (disp_valid) ok = 1'b1;
    end
  endtask

  // Call right after post(): returns once the block has consumed the FLUSH ready pulse.
  task automatic wait_convert(input string name);
    bit seen = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (conv_ready) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check({name, "_flush_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic expect_pub(input string name, input int ch, input logic [W_BCD-1:0] exp_bcd);
    int n;
    bit ok;
    wait_valid(300, n, ok);
    check({name, "_valid_in_time"}, 32'(ok), 32'd1);
    if (ok) begin
      check({name, "_bcd"}, 32'(disp_bcd), 32'(exp_bcd));
      check({name, "_src"}, 32'(disp_src), 32'(ch));
      check({name, "_ack"}, 32'(ack), 32'(1 << ch));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int  n, a1, v0;
    bit  ok;

    vecs[0] = '{0, 12'd255,  16'h0255};
    vecs[1] = '{2, 12'hE05,  16'hE005};
    vecs[2] = '{1, 12'd0,    16'h0000};
    vecs[3] = '{0, 12'd4095, 16'h4095};
    vecs[4] = '{2, 12'd999,  16'h0999};

    rst = 1'b1; req = '0; req_val = '0; stall = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_conv_bin", 32'(conv_bin), 32'd0);
    check("rst_disp_bcd", 32'(disp_bcd), 32'd0);
    check("rst_flags", {27'd0, ack, disp_valid, busy}, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Delay counted from the request edge through the end of the PUBLISH cycle.
    for (int i = 0; i < 5; i++) begin
      post(vecs[i].ch, vecs[i].val);
      wait_valid(300, n, ok);
      check($sformatf("vec%0d_valid_in_time", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d_bcd", i), 32'(disp_bcd), 32'(vecs[i].exp_bcd));
      check($sformatf("vec%0d_src", i), 32'(disp_src), 32'(vecs[i].ch));
      check($sformatf("vec%0d_ack", i), 32'(ack), 32'(1 << vecs[i].ch));
      check($sformatf("vec%0d_delay_%0d_in_66_127", i, n + 1),
            32'((n + 1 >= 66) && (n + 1 <= 127)), 32'd1);
      check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid_one_cycle", i), 32'(disp_valid), 32'd0);
    end

    // All three at once, then 0 and 2 together: pointer back at channel 0.
    req = 3'b111;
    req_val = {12'd999, 12'd4095, 12'd1};
    @(posedge clk); #1;
    req = '0;
    expect_pub("all3_first", 0, 16'h0001);
    expect_pub("all3_second", 1, 16'h4095);
    expect_pub("all3_third", 2, 16'h0999);
    req = 3'b101;
    req_val = {12'd3000, 12'd0, 12'd10};
    @(posedge clk); #1;
    req = '0;
    expect_pub("rr_wrap_first", 0, 16'h0010);
    expect_pub("rr_wrap_second", 2, 16'h3000);

    // Re-request on channel 1 while its first value is converting.
    a1 = ack_cnt[1];
    post(1, 12'd7);
    wait_convert("rereq");
    post(1, 12'd42);
    expect_pub("rereq_old", 1, 16'h0007);
    expect_pub("rereq_new", 1, 16'h0042);
    repeat (150) @(posedge clk); #1;
    check("rereq_ack1_count", 32'(ack_cnt[1] - a1), 32'd2);

    // Stalled converter: watchdog fires TIMEOUT cycles into FLUSH.
    stall = 1'b1;
    post(0, 12'd321);
    n = 0;
    while (n < 300 && !err) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_err_delay", 32'(n), 32'(TIMEOUT + 2));
    check("stall_idle_after_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("stall_regrant", 32'(busy), 32'd1);
    stall = 1'b0;
    expect_pub("stall_release", 0, 16'h0321);
    check("stall_err_sticky", 32'(err), 32'd1);

    // Reset in CONVERT: outputs clear without a clock edge, the request is lost.
    post(2, 12'd888);
    wait_convert("rst_mid");
    rst = 1'b1;
    #1;
    check("rst_mid_conv_bin", 32'(conv_bin), 32'd0);
    check("rst_mid_disp", {14'd0, disp_src, disp_bcd}, 32'd0);
    check("rst_mid_flags", {26'd0, ack, disp_valid, busy, err}, 32'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    v0 = valid_cnt;
    post(1, 12'd56);
    expect_pub("post_rst", 1, 16'h0056);
    check("post_rst_err", 32'(err), 32'd0);
    repeat (150) @(posedge clk); #1;
    check("post_rst_single_publish", 32'(valid_cnt - v0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
